alu_req_sequencer: RTL

- Requester-side front end for the team's 1-cycle-registered 4-bit ALU.
- Accepts operation requests over a valid/ready handshake and drives the ALU operand/opcode inputs.
- Captures the ALU result one cycle later and returns it in order through a response FIFO, tagged with a sequence number and an error flag.
- Credit-based issue means the block never loses a result under response back-pressure.

---
 rtl/alu_req_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_req_sequencer.sv
// Requester front end for the 1-cycle-registered ALU: valid/ready issue, one in-flight
// capture stage, and a credit-protected in-order response FIFO with sequence tags.
module alu_req_sequencer #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic [1:0]       req_op,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [1:0]       alu_op,
    input  logic [W-1:0]     alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      ops_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;

    typedef struct packed {
        logic [W-1:0]     data;
        logic             err;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             infl_v;
    logic             infl_err;
    logic [TAG_W-1:0] infl_tag;
    logic [TAG_W-1:0] tag_ctr;
    logic [15:0]      ops_cnt;
    logic             accept;
    logic             pop;
    logic [OW-1:0]    occupancy;

    assign alu_a  = req_a;
    assign alu_b  = req_b;
    assign alu_op = (req_op == 2'b11) ? 2'b00 : req_op;

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign accept    = req_valid && req_ready;

    // Credits count the in-flight slot too, so the capture stage always has a FIFO slot waiting.
    assign occupancy = OW'(count) + OW'(infl_v) - OW'(pop);
    assign req_ready = reset && (occupancy < OW'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            infl_v   <= 1'b0;
            infl_err <= 1'b0;
            infl_tag <= '0;
            tag_ctr  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            infl_v <= accept;
            if (accept) begin
                infl_err <= (req_op == 2'b11);
                infl_tag <= tag_ctr;
                tag_ctr  <= tag_ctr + TAG_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ops_cnt <= '0;
        end else begin
            if (infl_v) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                ops_cnt <= ops_cnt + 16'd1;
            end
            count <= count + CW'(infl_v) - CW'(pop);
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (infl_v) begin
            mem[wr_ptr] <= entry_t'{
                data: infl_err ? '0 : alu_result,
                err:  infl_err,
                tag:  infl_tag
            };
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        head     = '0;
        rsp_data = '0;
        rsp_err  = 1'b0;
        rsp_tag  = '0;
        if (rsp_valid) begin
            head     = mem[rd_ptr];
            rsp_data = head.data;
            rsp_err  = head.err;
            rsp_tag  = head.tag;
        end
    end

    assign ops_done = ops_cnt;

endmodule
